// File: rtl/wb_arbiter2.sv
// Two-requester Wishbone (pipelined) arbiter with bus lock and last-grant tie-break.
// Define WB_ARBITER2_TIMEOUT_EN to build in the ack watchdog, S_ABORT state and timeout_o.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_stall_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_stall_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic        s_stall_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {StIdle, StG0, StG1, StAbort} state_e;

    state_e state_q, state_d;
    logic   lg_q, lg_d;
    logic   gnt0, gnt1;
    logic   timeout_hit;

    // Reset also gates the muxes so nothing leaks through during the reset cycle itself.
    assign gnt0  = !rst_i && (state_q == StG0);
    assign gnt1  = !rst_i && (state_q == StG1);
    assign gnt_o = {gnt1, gnt0};

    always_comb begin
        state_d = state_q;
        lg_d    = lg_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) state_d = lg_q ? StG0 : StG1;
                else if (m0_cyc_i)        state_d = StG0;
                else if (m1_cyc_i)        state_d = StG1;
            end
            StG0: begin
                if (!m0_cyc_i)        state_d = m1_cyc_i ? StG1 : StIdle;
                else if (timeout_hit) state_d = StAbort;
            end
            StG1: begin
                if (!m1_cyc_i)        state_d = m0_cyc_i ? StG0 : StIdle;
                else if (timeout_hit) state_d = StAbort;
            end
            StAbort: begin
                if (!(lg_q ? m1_cyc_i : m0_cyc_i)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StG0 && state_q != StG0) lg_d = 1'b0;
        if (state_d == StG1 && state_q != StG1) lg_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            lg_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            lg_q    <= lg_d;
        end
    end

    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_sel_o    = 4'h0;
        s_adr_o    = 32'h0;
        s_dat_o    = 32'h0;
        m0_ack_o   = 1'b0;
        m0_stall_o = 1'b1;
        m0_dat_o   = 32'h0;
        m1_ack_o   = 1'b0;
        m1_stall_o = 1'b1;
        m1_dat_o   = 32'h0;
        if (gnt0) begin
            s_cyc_o    = m0_cyc_i;
            s_stb_o    = m0_stb_i;
            s_we_o     = m0_we_i;
            s_sel_o    = m0_sel_i;
            s_adr_o    = m0_adr_i;
            s_dat_o    = m0_dat_i;
            m0_ack_o   = s_ack_i;
            m0_stall_o = s_stall_i;
            m0_dat_o   = s_dat_i;
        end
        if (gnt1) begin
            s_cyc_o    = m1_cyc_i;
            s_stb_o    = m1_stb_i;
            s_we_o     = m1_we_i;
            s_sel_o    = m1_sel_i;
            s_adr_o    = m1_adr_i;
            s_dat_o    = m1_dat_i;
            m1_ack_o   = s_ack_i;
            m1_stall_o = s_stall_i;
            m1_dat_o   = s_dat_i;
        end
    end

`ifdef WB_ARBITER2_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q;
    logic        counting;

    // Counts granted cycles spent waiting on an outstanding strobe without an ack.
    assign counting    = (gnt0 || gnt1) && s_stb_o && !s_ack_i;
    assign timeout_hit = counting && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
    assign timeout_o   = timeout_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!(gnt0 || gnt1) || (state_d != state_q) || s_ack_i) cnt_d = 16'h0;
        else if (counting)                                      cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= 16'h0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= (state_d == StAbort) && (state_q != StAbort);
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: RAM target, two master drivers, per-cycle reference model.
module tb_wb_arbiter2;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_wdat [2];
    logic        m_ack [2];
    logic        m_stall [2];
    logic [31:0] m_rdat [2];
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        s_ack = 1'b0;
    logic        s_stall = 1'b0;
    logic [31:0] s_rdat = 32'h0;
    logic [1:0]  gnt;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_ack_o(m_ack[0]),
        .m0_stall_o(m_stall[0]), .m0_dat_o(m_rdat[0]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_ack_o(m_ack[1]),
        .m1_stall_o(m_stall[1]), .m1_dat_o(m_rdat[1]),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
        .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_stall_i(s_stall), .s_dat_i(s_rdat),
        .gnt_o(gnt), .timeout_o(timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM target: never stalls, acks one cycle after accepting a strobe (unless noack).
    logic [31:0] mem [0:255];
    bit          noack = 1'b0;
    logic        r_acc, r_we;
    logic [31:0] r_adr, r_dat;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hCAFE_0100;
        forever begin
            @(negedge clk);
            r_acc = s_cyc && s_stb && !s_stall;
            r_we  = s_we;
            r_adr = s_adr;
            r_dat = s_wdat;
            @(posedge clk);
            if (r_acc && r_we) mem[r_adr[9:2]] = r_dat;
            #1;
            s_ack  = r_acc && !noack;
            s_rdat = (r_acc && !r_we) ? mem[r_adr[9:2]] : 32'h0;
        end
    end

    // Reference model: owner -1 none, 0/1 granted master, 2 aborting (offender in last).
    int   owner = -1;
    int   last = 1;
    int   waited = 0;
    bit   to_pulse = 1'b0;
    int   g, x;
    logic [1:0] e_gnt;

    always @(negedge clk) begin
        g = -1;
        if (!rst_i && (owner == 0 || owner == 1)) g = owner;
        e_gnt = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        chk("gnt", 64'(gnt), 64'(e_gnt));
`ifdef WB_ARBITER2_TIMEOUT_EN
        chk("timeout", 64'(timeout), 64'(to_pulse));
`else
        chk("timeout", 64'(timeout), 64'd0);
`endif
        if (g >= 0) begin
            chk("s_ctl", {s_cyc, s_stb, s_we, s_sel, s_adr},
                {m_cyc[g], m_stb[g], m_we[g], m_sel[g], m_adr[g]});
            chk("s_dat", 64'(s_wdat), 64'(m_wdat[g]));
        end else begin
            chk("s_ctl", {s_cyc, s_stb, s_we, s_sel, s_adr}, 64'd0);
            chk("s_dat", 64'(s_wdat), 64'd0);
        end
        for (int i = 0; i < 2; i++) begin
            if (g == i) chk("m_rsp", {m_ack[i], m_stall[i], m_rdat[i]}, {s_ack, s_stall, s_rdat});
            else        chk("m_rsp", {m_ack[i], m_stall[i], m_rdat[i]}, {1'b0, 1'b1, 32'h0});
        end
        if (rst_i) begin
            owner = -1; last = 1; waited = 0; to_pulse = 1'b0;
        end else begin
            to_pulse = 1'b0;
            if (owner == -1) begin
                if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
                else if (m_cyc[0])        owner = 0;
                else if (m_cyc[1])        owner = 1;
                if (owner != -1) begin last = owner; waited = 0; end
            end else if (owner == 2) begin
                if (!m_cyc[last]) owner = -1;
            end else begin
                x = owner;
                if (!m_cyc[x]) begin
                    if (m_cyc[1-x]) begin owner = 1 - x; last = owner; end
                    else owner = -1;
                    waited = 0;
                end
`ifdef WB_ARBITER2_TIMEOUT_EN
                else if (s_ack) waited = 0;
                else if (m_stb[x]) begin
                    waited++;
                    if (waited >= TO) begin owner = 2; to_pulse = 1'b1; end
                end
`endif
            end
        end
    end

    logic [31:0] rd_buf [2][8];
    int          gnt_hits [2];

    // Pipelined master: issues n transfers under one cyc, records read data and grant at ack.
    task automatic run_master(input int m, input int n, input bit we, input logic [31:0] base,
                              input logic [31:0] dbase);
        int iss = 0;
        int acks = 0;
        int guard = 0;
        @(posedge clk); #1;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we; m_sel[m] = 4'hF;
        m_adr[m] = base; m_wdat[m] = we ? dbase : 32'h0;
        gnt_hits[m] = 0;
        while (acks < n && guard < 200) begin
            @(negedge clk);
            if (m_stb[m] && !m_stall[m]) iss++;
            if (m_ack[m]) begin
                rd_buf[m][acks] = m_rdat[m];
                if (gnt[m]) gnt_hits[m]++;
                acks++;
            end
            guard++;
            @(posedge clk); #1;
            if (iss < n) begin
                m_adr[m]  = base + 32'(4 * iss);
                m_wdat[m] = we ? dbase + 32'(iss) : 32'h0;
            end else begin
                m_stb[m] = 1'b0;
            end
        end
        chk($sformatf("m%0d_ack_count", m), 64'(acks), 64'(n));
        m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
    endtask

    logic [1:0] hist [12];
    int f0, f1, first, pulses, n01;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_sel[i] = 4'h0; m_adr[i] = 32'h0; m_wdat[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc), 64'd0);
        chk("rst_stalls", {m_stall[0], m_stall[1]}, 64'b11);
        @(posedge clk); #1 rst_i = 1'b0;

        // Single read by m0.
        fork
            run_master(0, 1, 1'b0, 32'h100, 32'h0);
            begin
                @(posedge clk); @(posedge clk); @(negedge clk);
                chk("req027_gnt", 64'(gnt), 64'b01);
                chk("req027_m1_stall", 64'(m_stall[1]), 64'd1);
            end
        join
        chk("req027_rdata", 64'(rd_buf[0][0]), 64'hCAFE_0100);

        // Simultaneous request after reset: m0 first, direct handover to m1.
        pulse_reset();
        fork
            run_master(0, 1, 1'b0, 32'h100, 32'h0);
            run_master(1, 1, 1'b0, 32'h100, 32'h0);
            for (int i = 0; i < 12; i++) begin @(negedge clk); hist[i] = gnt; end
        join
        f0 = -1; f1 = -1;
        for (int i = 0; i < 12; i++) begin
            if (f0 < 0 && hist[i] != 2'b00) f0 = i;
            if (f1 < 0 && hist[i] == 2'b10) f1 = i;
        end
        chk("req028_first_grant", 64'((f0 >= 0) ? hist[f0] : 2'b11), 64'b01);
        chk("req028_handover", 64'((f1 > 0) ? hist[f1-1] : 2'b11), 64'b01);

        // m1 locks the bus for 8 writes while m0 waits, then m0 writes 8.
        fork
            run_master(1, 8, 1'b1, 32'h300, 32'h1111_0000);
            begin repeat (2) @(posedge clk); run_master(0, 8, 1'b1, 32'h200, 32'h2222_0000); end
        join
        chk("req029_m1_gnt_hits", 64'(gnt_hits[1]), 64'd8);
        chk("req029_m0_gnt_hits", 64'(gnt_hits[0]), 64'd8);
        run_master(0, 8, 1'b0, 32'h300, 32'h0);
        for (int k = 0; k < 8; k++) chk("req029_rb_m1", 64'(rd_buf[0][k]), 64'(32'h1111_0000 + k));
        run_master(1, 8, 1'b0, 32'h200, 32'h0);
        for (int k = 0; k < 8; k++) chk("req029_rb_m0", 64'(rd_buf[1][k]), 64'(32'h2222_0000 + k));

        // Reset in the middle of an m1 write.
        @(posedge clk); #1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_sel[1] = 4'hF;
        m_adr[1] = 32'h40; m_wdat[1] = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        chk("req030_pre_gnt", 64'(gnt), 64'b10);
        @(posedge clk); #1 rst_i = 1'b1;
        @(negedge clk);
        chk("req030_no_ack_rst", 64'(m_ack[1]), 64'd0);
        @(posedge clk); #1 rst_i = 1'b0;
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
        @(negedge clk);
        chk("req030_s_cyc", 64'(s_cyc), 64'd0);
        chk("req030_gnt", 64'(gnt), 64'b00);
        chk("req030_no_ack", 64'(m_ack[1]), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = 1'b0; m_adr[i] = 32'h100;
        end
        @(posedge clk); @(negedge clk);
        chk("req030_tie", 64'(gnt), 64'b01);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin m_cyc[i] = 1'b0; m_stb[i] = 1'b0; end
        repeat (3) @(posedge clk);

        // Target never acks while m0 holds the bus; m1 requests one cycle later.
        noack = 1'b1;
        #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h100;
        @(posedge clk); #1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h100;
`ifdef WB_ARBITER2_TIMEOUT_EN
        first = -1; pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (timeout) begin pulses++; if (first < 0) first = i; end
            if (i == 8) begin
                chk("req031_abort_stall", 64'(m_stall[0]), 64'd1);
                chk("req031_abort_s_cyc", 64'(s_cyc), 64'd0);
                chk("req031_abort_gnt", 64'(gnt), 64'b00);
            end
        end
        chk("req031_pulse_at", 64'(first), 64'd5);
        chk("req031_pulses", 64'(pulses), 64'd1);
        @(posedge clk); #1 m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("req031_m1_gnt", 64'(gnt), 64'b10);
`else
        n01 = 0; pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (gnt == 2'b01) n01++;
            if (timeout) pulses++;
        end
        chk("req032_held", 64'(n01), 64'd1000);
        chk("req032_no_timeout", 64'(pulses), 64'd0);
        @(posedge clk); #1 m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("req032_m1_gnt", 64'(gnt), 64'b10);
`endif
        @(posedge clk); #1 m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        noack = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
